insn_encoder_loader: RTL and testbench

Encoding counterpart of the processor's instruction decoder. It accepts field-level instruction requests from a test/boot sequencer and packs each into a 32-bit word in the processor ISA format. Words are buffered in a small FIFO and drained into instruction memory over a write handshake, at sequential addresses. It is used to load programs whose words the decoder later turns back into control signals.

---
 rtl/insn_pkg.sv | 29 ++
 rtl/insn_enc_fifo.sv | 54 +++++
 rtl/insn_encoder_loader.sv | 120 ++++++++++++
 tb/tb_insn_encoder_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_pkg.sv
// Shared ISA definitions: opcodes, request kinds and instruction field positions.
// Used by both the instruction decoder and the encoder/loader.
package insn_pkg;

    // Major opcodes in bits [31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    // Field LSB positions
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned ALUOP_LSB = 2;
    localparam int unsigned IMM_LSB   = 0;

    // Request kinds; codes 5-7 are illegal
    typedef enum logic [2:0] {
        KindNop  = 3'd0,
        KindRAlu = 3'd1,
        KindAddi = 3'd2,
        KindSw   = 3'd3,
        KindLw   = 3'd4
    } req_kind_e;

endpackage

// File: rtl/insn_enc_fifo.sv
// Parameterized synchronous FIFO (power-of-2 depth) buffering encoded words.
// Storage is not reset; the consumer masks head while empty.
module insn_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Full/empty status and guarded push/pop
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Word storage write
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/insn_encoder_loader.sv
// Packs field-level instruction requests into 32-bit ISA words, buffers them
// and drains them into instruction memory at sequential addresses.
// Optional: define INSN_ENC_CHECK_EN to drop illegal kinds (5-7) and pulse err;
// otherwise illegal kinds encode as NOP and err is tied low.
module insn_encoder_loader
    import insn_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_shamt,
    input  logic [4:0]        req_aluop,
    input  logic [16:0]       req_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              idle,
    output logic              err
);

    logic [31:0]       enc_word;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [31:0]       head;
    logic [ADDR_W-1:0] addr_q;

    // Encode the current request into an ISA word
    always_comb begin
        enc_word = '0;
        unique case (req_kind)
            KindRAlu: begin
                enc_word[OP_LSB +: 5]    = OP_RTYPE;
                enc_word[RD_LSB +: 5]    = req_rd;
                enc_word[RS_LSB +: 5]    = req_rs;
                enc_word[RT_LSB +: 5]    = req_rt;
                enc_word[SHAMT_LSB +: 5] = req_shamt;
                enc_word[ALUOP_LSB +: 5] = req_aluop;
            end
            KindAddi, KindSw, KindLw: begin
                enc_word[OP_LSB +: 5]   = (req_kind == KindAddi) ? OP_ADDI :
                                          (req_kind == KindSw)   ? OP_SW   : OP_LW;
                enc_word[RD_LSB +: 5]   = req_rd;
                enc_word[RS_LSB +: 5]   = req_rs;
                enc_word[IMM_LSB +: 17] = req_imm;
            end
            default: enc_word = '0;  // NOP and illegal kinds
        endcase
    end

    // Handshake and drain control
    always_comb begin
        req_ready = !full;
        accept    = req_valid && !full;
        imem_we   = !empty;
        pop       = !empty && imem_ready;
        imem_addr = addr_q;
        imem_data = empty ? 32'h0 : head;
        idle      = empty;
    end

`ifdef INSN_ENC_CHECK_EN
    logic illegal;
    logic err_q;

    // Illegal kinds are consumed but not buffered
    always_comb begin
        illegal = (req_kind > 3'd4);
        push    = accept && !illegal;
        err     = err_q;
    end

    // One-cycle error pulse following an accepted illegal request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= accept && illegal;
    end
`else
    // Every accepted request is buffered; illegal kinds already encode as NOP
    always_comb begin
        push = accept;
        err  = 1'b0;
    end
`endif

    // Write address counter; base_load wins over a same-cycle increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          addr_q <= '0;
        else if (base_load) addr_q <= base_addr;
        else if (pop)       addr_q <= addr_q + ADDR_W'(1);
    end

    insn_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed self-checking bench for insn_encoder_loader (DEPTH=4, ADDR_W=12).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_insn_encoder_loader;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_shamt;
    logic [4:0]  req_aluop;
    logic [16:0] req_imm;
    logic        base_load;
    logic [11:0] base_addr;
    logic        imem_we;
    logic        imem_ready;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        idle;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    insn_encoder_loader #(
        .DEPTH  (4),
        .ADDR_W (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rd     (req_rd),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_shamt  (req_shamt),
        .req_aluop  (req_aluop),
        .req_imm    (req_imm),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .idle       (idle),
        .err        (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] op,
                             input logic [16:0] imm);
        req_valid = 1'b1;
        req_kind  = k;
        req_rd    = rd;
        req_rs    = rs;
        req_rt    = rt;
        req_shamt = sh;
        req_aluop = op;
        req_imm   = imm;
    endtask

    // Synchronous-looking reset pulse applied on a falling edge
    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        req_valid  = 1'b0;
        imem_ready = 1'b0;
        base_load  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_kind   = '0;
        req_rd     = '0;
        req_rs     = '0;
        req_rt     = '0;
        req_shamt  = '0;
        req_aluop  = '0;
        req_imm    = '0;
        base_load  = 1'b0;
        base_addr  = '0;
        imem_ready = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_we",    32'(imem_we),   32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_data",  imem_data,      32'h0);
        check("rst_idle",  32'(idle),      32'd1);
        check("rst_err",   32'(err),       32'd0);
        reset = 1'b0;

        // ADDI rd=1 rs=0 imm=5: visible one cycle after acceptance
        @(negedge clock);
        drive_req(3'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5);
        @(negedge clock);
        req_valid = 1'b0;
        check("addi_we",   32'(imem_we),   32'd1);
        check("addi_addr", 32'(imem_addr), 32'd0);
        check("addi_data", imem_data,      32'h28400005);
        check("addi_idle", 32'(idle),      32'd0);

        // LW then R-ALU, back-to-back drain
        do_reset();
        imem_ready = 1'b1;
        drive_req(3'd4, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'd4);
        @(negedge clock);
        check("lw_data", imem_data,      32'h40860004);
        check("lw_addr", 32'(imem_addr), 32'd0);
        drive_req(3'd1, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'h1ffff);
        @(negedge clock);
        req_valid = 1'b0;
        check("r_we",   32'(imem_we),   32'd1);
        check("r_data", imem_data,      32'h00C22000);
        check("r_addr", 32'(imem_addr), 32'd1);
        @(negedge clock);
        check("lwr_idle", 32'(idle),      32'd1);
        check("lwr_addr", 32'(imem_addr), 32'd2);

        // Fill past DEPTH while stalled, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(req_ready), 32'd1);
            drive_req(3'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'(8 + i));
            @(negedge clock);
        end
        drive_req(3'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd12);
        check("full_ready", 32'(req_ready), 32'd0);
        check("stall_data", imem_data,      32'h38400008);
        @(negedge clock);
        check("hold_ready", 32'(req_ready), 32'd0);
        check("hold_data",  imem_data,      32'h38400008);
        check("hold_addr",  32'(imem_addr), 32'd0);
        imem_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k >= 2) req_valid = 1'b0;
            check("drain_we",   32'(imem_we),   32'd1);
            check("drain_data", imem_data,      32'h38400008 + 32'(k));
            check("drain_addr", 32'(imem_addr), 32'(k));
        end
        @(negedge clock);
        check("drain_idle", 32'(idle),      32'd1);
        check("drain_end",  32'(imem_addr), 32'd5);

        // Address wrap after base_load
        do_reset();
        base_load = 1'b1;
        base_addr = 12'hFFE;
        @(negedge clock);
        base_load = 1'b0;
        check("base_addr", 32'(imem_addr), 32'hFFE);
        imem_ready = 1'b1;
        drive_req(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd1);
        @(negedge clock);
        check("wrap0", 32'(imem_addr), 32'hFFE);
        drive_req(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd2);
        @(negedge clock);
        check("wrap1", 32'(imem_addr), 32'hFFF);
        drive_req(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd3);
        @(negedge clock);
        req_valid = 1'b0;
        check("wrap2",      32'(imem_addr), 32'h000);
        check("wrap2_data", imem_data,      32'h28420003);

        // base_load beats a completing write; that word used the old address
        do_reset();
        drive_req(3'd2, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 17'd7);
        @(negedge clock);
        drive_req(3'd2, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 17'd9);
        @(negedge clock);
        req_valid  = 1'b0;
        check("prio_old", 32'(imem_addr), 32'd0);
        imem_ready = 1'b1;
        base_load  = 1'b1;
        base_addr  = 12'h100;
        @(negedge clock);
        base_load  = 1'b0;
        imem_ready = 1'b0;
        check("prio_addr", 32'(imem_addr), 32'h100);
        check("prio_data", imem_data,      32'h29400009);

        // Asynchronous reset mid-stall discards buffered words
        do_reset();
        drive_req(3'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd1);
        @(negedge clock);
        drive_req(3'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd2);
        @(negedge clock);
        req_valid = 1'b0;
        check("pre_rst_we", 32'(imem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_we",    32'(imem_we),   32'd0);
        check("arst_idle",  32'(idle),      32'd1);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_data",  imem_data,      32'h0);
        @(negedge clock);
        reset      = 1'b0;
        imem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("post_rst_we", 32'(imem_we), 32'd0);
        end
        check("post_rst_addr", 32'(imem_addr), 32'd0);

        // Illegal kind 6
        do_reset();
        drive_req(3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 17'd77);
        @(negedge clock);
        req_valid = 1'b0;
`ifdef INSN_ENC_CHECK_EN
        check("ill_err", 32'(err),     32'd1);
        check("ill_we",  32'(imem_we), 32'd0);
        @(negedge clock);
        check("ill_err_end", 32'(err),     32'd0);
        check("ill_we_end",  32'(imem_we), 32'd0);
`else
        check("ill_we",   32'(imem_we), 32'd1);
        check("ill_data", imem_data,    32'h0);
        check("ill_err",  32'(err),     32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
